// File: rtl/ap_prof_pkg.sv
// Shared types for the ap_ctrl_hs transaction profiler: record layout, FSM states
// and the overflow saturation value.
package ap_prof_pkg;

  // Record fields are sized for the widest supported configuration; the top
  // zero-extends narrower CNT_W/ID_W values into them.
  localparam int REC_CNT_W = 32;
  localparam int REC_ID_W  = 16;

  localparam logic [15:0] OVF_SAT = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} prof_state_e;

  typedef struct packed {
    logic [REC_ID_W-1:0]  id;
    logic [REC_CNT_W-1:0] latency;
    logic [REC_CNT_W-1:0] interval;
    logic [REC_CNT_W-1:0] stall;
  } prof_rec_t;

endpackage

// File: rtl/prof_sync_fifo.sv
// Single-clock show-ahead FIFO: rdata is the head entry whenever empty is low.
// A push while full succeeds only if a pop happens in the same cycle.
module prof_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         wr, rd;

  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    wr    = push & (~full | pop);
    rd    = pop & ~empty;
    rdata = mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + (AW+1)'(1);
      if (rd) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ap_txn_profiler.sv
// Per-transaction latency / interval / stall profiler for an ap_ctrl_hs block.
// Accept timestamps queue in flight; each completion emits one record downstream.
module ap_txn_profiler
  import ap_prof_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int ID_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [ID_W-1:0]  rec_id,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [CNT_W-1:0] rec_stall,
  output logic [15:0]      overflow_cnt,
  output logic             proto_err,
  output logic             finished
);

  prof_state_e      state;
  logic [CNT_W-1:0] cyc, last_acc, stall_cnt;
  logic             have_acc;
  logic [ID_W-1:0]  next_id;

  logic             acc_req, acc_ok, cmpl, bypass, rec_gen, drop;
  logic             if_push, if_pop, if_full, if_empty;
  logic             rec_push, rec_pop, rec_full, rec_empty;
  logic [CNT_W-1:0] ival, lat, if_ts, if_ival;
  prof_rec_t        rec_in, rec_out;

  always_comb begin
    acc_req  = ap_start & ap_ready & ((state == IDLE) || (state == RUN));
    acc_ok   = acc_req & ~if_full;
    cmpl     = ap_done & ap_continue & (state != DONE);
    // Same-cycle accept and completion with nothing in flight never touches the queue.
    bypass   = cmpl & acc_ok & if_empty;
    if_push  = acc_ok & ~bypass;
    if_pop   = cmpl & ~if_empty;
    rec_gen  = bypass | if_pop;
    ival     = have_acc ? (cyc - last_acc) : '0;
    lat      = bypass ? '0 : (cyc - if_ts);
    rec_pop  = ~rec_empty & rec_ready;
    rec_push = rec_gen & (~rec_full | rec_pop);
    drop     = rec_gen & rec_full & ~rec_pop;

    rec_in          = '0;
    rec_in.id       = REC_ID_W'(next_id);
    rec_in.latency  = REC_CNT_W'(lat);
    rec_in.interval = REC_CNT_W'(bypass ? ival : if_ival);
    rec_in.stall    = REC_CNT_W'(stall_cnt);

    rec_valid    = ~rec_empty;
    rec_id       = rec_valid ? rec_out.id[ID_W-1:0]        : '0;
    rec_latency  = rec_valid ? rec_out.latency[CNT_W-1:0]  : '0;
    rec_interval = rec_valid ? rec_out.interval[CNT_W-1:0] : '0;
    rec_stall    = rec_valid ? rec_out.stall[CNT_W-1:0]    : '0;
  end

  prof_sync_fifo #(.W(2*CNT_W), .DEPTH(DEPTH)) u_inflight (
    .clock (clock),
    .reset (reset),
    .push  (if_push),
    .wdata ({cyc, ival}),
    .pop   (if_pop),
    .rdata ({if_ts, if_ival}),
    .full  (if_full),
    .empty (if_empty)
  );

  prof_sync_fifo #(.W($bits(prof_rec_t)), .DEPTH(DEPTH)) u_records (
    .clock (clock),
    .reset (reset),
    .push  (rec_push),
    .wdata (rec_in),
    .pop   (rec_pop),
    .rdata (rec_out),
    .full  (rec_full),
    .empty (rec_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc          <= '0;
      last_acc     <= '0;
      have_acc     <= 1'b0;
      stall_cnt    <= '0;
      next_id      <= '0;
      overflow_cnt <= '0;
      proto_err    <= 1'b0;
    end else begin
      cyc <= cyc + CNT_W'(1);
      if (acc_ok) begin
        last_acc <= cyc;
        have_acc <= 1'b1;
      end
      if (cmpl)                         stall_cnt <= '0;
      else if (ap_done & ~ap_continue)  stall_cnt <= stall_cnt + CNT_W'(1);
      // Dropped records still consume an id so gaps are visible downstream.
      if (rec_gen)                      next_id <= next_id + ID_W'(1);
      if (drop && overflow_cnt != OVF_SAT) overflow_cnt <= overflow_cnt + 16'd1;
      if ((cmpl & if_empty & ~bypass) | (acc_req & if_full)) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      finished <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (finish) state <= DRAIN;
               else if (acc_ok) state <= RUN;
        RUN:   if (finish) state <= DRAIN;
        DRAIN: if (if_empty && rec_empty) begin
                 state    <= DONE;
                 finished <= 1'b1;
               end
        DONE:  state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_txn_profiler.sv
// Randomized and directed bench for ap_txn_profiler with a queue-based reference model.
module tb_ap_txn_profiler;

  localparam int CNT_W = 8;
  localparam int ID_W  = 16;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ap_start = 0, ap_ready = 0, ap_done = 0, ap_continue = 0, finish = 0, rec_ready = 0;
  logic             rec_valid, proto_err, finished;
  logic [ID_W-1:0]  rec_id;
  logic [CNT_W-1:0] rec_latency, rec_interval, rec_stall;
  logic [15:0]      overflow_cnt;

  always #5 clock = ~clock;

  ap_txn_profiler #(.CNT_W(CNT_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
    .rec_latency(rec_latency), .rec_interval(rec_interval), .rec_stall(rec_stall),
    .overflow_cnt(overflow_cnt), .proto_err(proto_err), .finished(finished)
  );

  typedef struct { int id; int lat; int ival; int stall; } mrec_t;
  typedef struct { int ts; int ival; } mif_t;

  mrec_t recq[$];
  mif_t  ifq[$];
  int    m_cyc, tcyc, m_id, m_stall, m_last, m_ovf;
  bit    m_have, m_perr, m_drain, m_done;
  int    checks = 0, errors = 0;
  bit    cmp_en = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  task automatic model_clear();
    recq.delete(); ifq.delete();
    m_cyc = 0; tcyc = 0; m_id = 0; m_stall = 0; m_last = 0; m_ovf = 0;
    m_have = 0; m_perr = 0; m_drain = 0; m_done = 0;
  endtask

  // One clock edge of profiler behaviour, from the inputs sampled at that edge.
  task automatic model_step();
    int    if_n   = ifq.size();
    int    rq_n   = recq.size();
    bit    pop_r  = (rq_n > 0) && rec_ready;
    bit    acc    = ap_start && ap_ready && !m_drain && !m_done;
    bit    cmpl   = ap_done && ap_continue && !m_done;
    bit    acc_ok = acc && (if_n < DEPTH);
    int    ival   = m_have ? ((m_cyc - m_last) & MASK) : 0;
    bit    gen = 0, byp = 0;
    mrec_t r;
    mif_t  e;
    if (acc && !acc_ok) m_perr = 1;
    if (cmpl) begin
      if (if_n > 0) begin
        e = ifq.pop_front();
        r = '{m_id, (m_cyc - e.ts) & MASK, e.ival, m_stall};
        gen = 1;
      end else if (acc_ok) begin
        r = '{m_id, 0, ival, m_stall};
        gen = 1; byp = 1;
      end else m_perr = 1;
      m_stall = 0;
    end else if (ap_done && !ap_continue) m_stall = (m_stall + 1) & MASK;
    if (acc_ok) begin
      if (!byp) ifq.push_back('{m_cyc, ival});
      m_last = m_cyc; m_have = 1;
    end
    if (pop_r) void'(recq.pop_front());
    if (gen) begin
      if (rq_n - int'(pop_r) < DEPTH) recq.push_back(r);
      else if (m_ovf < 65535) m_ovf++;
      m_id = (m_id + 1) & 16'hFFFF;
    end
    if (!m_done) begin
      if (m_drain) begin
        if (if_n == 0 && rq_n == 0) m_done = 1;
      end else if (finish) m_drain = 1;
    end
    m_cyc = (m_cyc + 1) & MASK;
    tcyc++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
  endtask

  task automatic run_to(input int c);
    idle();
    while (tcyc < c) tick();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    idle();
    model_clear();
    release_reset();
  endtask

  task automatic expect_front(input string name, input int id, input int lat, input int ival, input int st);
    chk({name, "_valid"}, rec_valid, 1);
    chk({name, "_id"}, rec_id, id);
    chk({name, "_lat"}, rec_latency, lat);
    chk({name, "_ival"}, rec_interval, ival);
    chk({name, "_stall"}, rec_stall, st);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, rec_valid, 0);
    chk({name, "_id"}, rec_id, 0);
    chk({name, "_lat"}, rec_latency, 0);
    chk({name, "_ival"}, rec_interval, 0);
    chk({name, "_stall"}, rec_stall, 0);
    chk({name, "_ovf"}, overflow_cnt, 0);
    chk({name, "_perr"}, proto_err, 0);
    chk({name, "_fin"}, finished, 0);
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      if (recq.size() > 0) begin
        chk("cmp_valid", rec_valid, 1);
        chk("cmp_id", rec_id, recq[0].id);
        chk("cmp_lat", rec_latency, recq[0].lat);
        chk("cmp_ival", rec_interval, recq[0].ival);
        chk("cmp_stall", rec_stall, recq[0].stall);
      end else begin
        chk("cmp_valid", rec_valid, 0);
        chk("cmp_idle_fields", {rec_id, rec_latency, rec_interval, rec_stall}, 0);
      end
      chk("cmp_ovf", overflow_cnt, m_ovf);
      chk("cmp_perr", proto_err, m_perr);
      chk("cmp_fin", finished, m_done);
    end
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clock);
    chk_all_zero("reset_state");
    release_reset();
    cmp_en = 1;

    // single transaction
    do_reset(); rec_ready = 0;
    run_to(5);  ap_start = 1; ap_ready = 1; tick();
    run_to(17); ap_done = 1; ap_continue = 1; tick(); idle();
    chk("single_at_cyc", tcyc, 18);
    expect_front("single", 0, 12, 0, 0);
    rec_ready = 1; tick();
    chk("single_popped", rec_valid, 0);

    // pipelined
    do_reset(); rec_ready = 0;
    while (tcyc < 40) begin
      ap_start = (tcyc == 10 || tcyc == 14 || tcyc == 18); ap_ready = ap_start;
      ap_done  = (tcyc == 30 || tcyc == 34 || tcyc == 38); ap_continue = ap_done;
      tick();
    end
    idle();
    expect_front("pipe0", 0, 20, 0, 0); rec_ready = 1; tick(); rec_ready = 0;
    expect_front("pipe1", 1, 20, 4, 0); rec_ready = 1; tick(); rec_ready = 0;
    expect_front("pipe2", 2, 20, 4, 0); rec_ready = 1; tick();
    chk("pipe_empty", rec_valid, 0);

    // downstream stall
    do_reset(); rec_ready = 0;
    while (tcyc < 16) begin
      ap_start = (tcyc == 2); ap_ready = ap_start;
      ap_done = (tcyc >= 12 && tcyc <= 15); ap_continue = (tcyc == 15);
      tick();
    end
    idle();
    expect_front("stall", 0, 13, 0, 3);

    // backpressure + overflow, using bypass transactions
    do_reset(); rec_ready = 0;
    run_to(3);
    ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1;
    repeat (9) tick();
    idle(); tick();
    chk("bp_ovf", overflow_cnt, 1);
    rec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      expect_front("bp_rec", i, 0, (i == 0) ? 0 : 1, 0);
      tick();
    end
    chk("bp_drained", rec_valid, 0);
    rec_ready = 0;
    ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1; tick(); idle();
    chk("bp_id_after_drop", rec_id, 9);

    // counter wrap
    do_reset(); rec_ready = 0;
    run_to(250); ap_start = 1; ap_ready = 1; tick();
    run_to(260); ap_done = 1; ap_continue = 1; tick(); idle();
    expect_front("wrap", 0, 10, 0, 0);

    // done with nothing in flight
    do_reset(); rec_ready = 1;
    run_to(3); ap_done = 1; ap_continue = 1; tick(); idle();
    chk("err_perr", proto_err, 1);
    chk("err_norec", rec_valid, 0);

    // drain with one transaction in flight
    do_reset(); rec_ready = 1;
    run_to(2); ap_start = 1; ap_ready = 1; tick(); idle();
    finish = 1; tick(); tick(); finish = 0;
    ap_start = 1; ap_ready = 1; tick(); idle();
    repeat (5) tick();
    chk("drain_not_yet", finished, 0);
    ap_done = 1; ap_continue = 1; tick(); idle();
    for (int k = 0; k < 20 && !finished; k++) tick();
    chk("drain_finished", finished, 1);
    chk("drain_perr", proto_err, 0);

    // async reset mid-run
    do_reset(); rec_ready = 0;
    ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1;
    repeat (3) tick();
    idle();
    chk("areset_pre_valid", rec_valid, 1);
    #2 reset = 1'b0;
    model_clear();
    #1 chk_all_zero("areset");
    release_reset();

    // randomized rounds
    for (int rnd = 0; rnd < 4; rnd++) begin
      do_reset();
      for (int n = 0; n < 1500; n++) begin
        ap_start    = ($urandom_range(0, 99) < 40);
        ap_ready    = ($urandom_range(0, 99) < 70);
        ap_continue = ($urandom_range(0, 99) < 70);
        ap_done     = (ifq.size() > 0) && ($urandom_range(0, 99) < 40);
        if (ifq.size() == DEPTH && ap_done && ap_continue) ap_start = 0;
        rec_ready   = ($urandom_range(0, 99) < ((rnd % 2 == 0) ? 90 : 20));
        finish      = (n > 1200) && ($urandom_range(0, 99) < 5);
        tick();
      end
      idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
